// File: rtl/game_timer_pkg.sv
// Shared types and default constants for the level countdown controller.
package game_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WARN,
        PAUSED,
        EXPIRED
    } timer_state_t;

    localparam int TIMER_W     = 8;
    localparam int TIMER_START = 60;
    localparam int TIMER_WARN  = 10;
    localparam int TIMER_MAX   = 255;

endpackage

// File: rtl/game_timer_ctrl.sv
// Level countdown controller: start/pause/resume/bonus/expire sequencing with
// saturating bonus arithmetic and a blink-gated timer display enable.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int TIME_W     = TIMER_W,
    parameter int START_TIME = TIMER_START,
    parameter int WARN_TIME  = TIMER_WARN,
    parameter int MAX_TIME   = TIMER_MAX
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              secTick,
    input  logic              blinkDuty50,
    input  logic              start,
    input  logic              pause,
    input  logic              resume,
    input  logic              abort,
    input  logic              addTime,
    input  logic [TIME_W-1:0] addAmount,
    output logic [TIME_W-1:0] timeLeft,
    output logic              running,
    output logic              warning,
    output logic              displayEn,
    output logic              timeUp
);

    localparam logic [TIME_W-1:0] START_VAL = TIME_W'(START_TIME);
    localparam logic [TIME_W:0]   WARN_EXT  = (TIME_W + 1)'(WARN_TIME);
    localparam logic [TIME_W:0]   MAX_EXT   = (TIME_W + 1)'(MAX_TIME);

    timer_state_t      state_q, state_d;
    logic              ret_warn_q, ret_warn_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              running_q, running_d;
    logic              warning_q, warning_d;
    logic              display_en_q, display_en_d;
    logic              time_up_q, time_up_d;

    logic              live;
    logic [TIME_W:0]   sum_w;
    logic [TIME_W:0]   next_w;

    // One extra bit of headroom so the bonus sum can be saturated before it wraps.
    always_comb begin
        sum_w = {1'b0, time_q} + (addTime ? {1'b0, addAmount} : '0);
        if (sum_w > MAX_EXT) begin
            sum_w = MAX_EXT;
        end
        next_w = sum_w;
        if (secTick && (sum_w != '0)) begin
            next_w = sum_w - 1'b1;
        end
    end

    assign live = (state_q == RUN) || (state_q == WARN);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        ret_warn_d = ret_warn_q;
        time_d     = time_q;
        time_up_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            time_d  = START_VAL;
        end else if (pause) begin
            if (live) begin
                state_d    = PAUSED;
                ret_warn_d = (state_q == WARN);
            end
        end else if (resume) begin
            if (state_q == PAUSED) begin
                state_d = ret_warn_q ? WARN : RUN;
            end
        end else if (live && (secTick || addTime)) begin
            time_d = next_w[TIME_W-1:0];
            if (next_w == '0) begin
                state_d   = EXPIRED;
                time_up_d = 1'b1;
            end else if (next_w <= WARN_EXT) begin
                state_d = WARN;
            end else begin
                state_d = RUN;
            end
        end

        running_d    = (state_d == RUN) || (state_d == WARN);
        warning_d    = (state_d == WARN);
        display_en_d = ((state_d == WARN) || (state_d == EXPIRED)) ? blinkDuty50 : 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= IDLE;
            ret_warn_q   <= 1'b0;
            time_q       <= START_VAL;
            running_q    <= 1'b0;
            warning_q    <= 1'b0;
            display_en_q <= 1'b1;
            time_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_warn_q   <= ret_warn_d;
            time_q       <= time_d;
            running_q    <= running_d;
            warning_q    <= warning_d;
            display_en_q <= display_en_d;
            time_up_q    <= time_up_d;
        end
    end

    assign timeLeft  = time_q;
    assign running   = running_q;
    assign warning   = warning_q;
    assign displayEn = display_en_q;
    assign timeUp    = time_up_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: a per-cycle behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_game_timer_ctrl;

    localparam int S_IDLE = 0, S_RUN = 1, S_WARN = 2, S_PAUSED = 3, S_EXPIRED = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       secTick = 1'b0;
    logic       blinkDuty50 = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       resume = 1'b0;
    logic       abort = 1'b0;
    logic       addTime = 1'b0;
    logic [7:0] addAmount = 8'd0;
    logic [7:0] timeLeft;
    logic       running;
    logic       warning;
    logic       displayEn;
    logic       timeUp;

    int vectors = 0;
    int miscompares = 0;

    int m_st  = S_IDLE;
    int m_ret = S_RUN;
    int m_t   = 60;
    int m_v   = 0;
    bit m_up  = 1'b0;
    bit m_disp = 1'b1;

    game_timer_ctrl dut (
        .clk        (clk),
        .resetN     (resetN),
        .secTick    (secTick),
        .blinkDuty50(blinkDuty50),
        .start      (start),
        .pause      (pause),
        .resume     (resume),
        .abort      (abort),
        .addTime    (addTime),
        .addAmount  (addAmount),
        .timeLeft   (timeLeft),
        .running    (running),
        .warning    (warning),
        .displayEn  (displayEn),
        .timeUp     (timeUp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the outputs must be after this edge, from the event rules.
    always @(posedge clk) begin
        if (!resetN) begin
            m_st = S_IDLE; m_t = 60; m_up = 1'b0; m_disp = 1'b1; m_ret = S_RUN;
        end else begin
            m_up = 1'b0;
            if (abort) begin
                m_st = S_IDLE;
            end else if (start) begin
                m_st = S_RUN; m_t = 60;
            end else if (pause) begin
                if (m_st == S_RUN || m_st == S_WARN) begin
                    m_ret = m_st; m_st = S_PAUSED;
                end
            end else if (resume) begin
                if (m_st == S_PAUSED) m_st = m_ret;
            end else if ((m_st == S_RUN || m_st == S_WARN) && (secTick || addTime)) begin
                m_v = m_t + (addTime ? int'(addAmount) : 0);
                if (m_v > 255) m_v = 255;
                if (secTick) m_v = m_v - 1;
                m_t = m_v;
                if (m_v == 0) begin
                    m_st = S_EXPIRED; m_up = 1'b1;
                end else if (m_v <= 10) begin
                    m_st = S_WARN;
                end else begin
                    m_st = S_RUN;
                end
            end
            m_disp = (m_st == S_WARN || m_st == S_EXPIRED) ? blinkDuty50 : 1'b1;
        end
        #1;
        check("timeLeft",  int'(timeLeft),  m_t);
        check("running",   int'(running),   int'(m_st == S_RUN || m_st == S_WARN));
        check("warning",   int'(warning),   int'(m_st == S_WARN));
        check("displayEn", int'(displayEn), int'(m_disp));
        check("timeUp",    int'(timeUp),    int'(m_up));
    end

    // Blink square wave, slower than the clock so both phases are seen in WARN.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            blinkDuty50 = ~blinkDuty50;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    // One call = one cycle of inputs, applied at the following posedge.
    task automatic step(input logic st, input logic pa, input logic re, input logic ab,
                        input logic ad, input logic [7:0] amt, input logic tk);
        @(negedge clk);
        start = st; pause = pa; resume = re; abort = ab;
        addTime = ad; addAmount = amt; secTick = tk;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 8'd0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'd0, 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetN = 1'b0;
        idle(); idle();
        @(negedge clk); resetN = 1'b1;
        settle();
        check("rst_timeLeft", int'(timeLeft), 60);
        check("rst_running", int'(running), 0);
        check("rst_displayEn", int'(displayEn), 1);

        step(1, 0, 0, 0, 0, 8'd0, 0); settle();
        check("start_running", int'(running), 1);

        ticks(30); idle(); settle();
        check("at30", int'(timeLeft), 30);
        step(0, 1, 0, 0, 0, 8'd0, 0);
        ticks(5);
        step(0, 0, 0, 0, 1, 8'd7, 0);
        idle(); settle();
        check("paused_hold", int'(timeLeft), 30);
        check("paused_running", int'(running), 0);
        step(0, 0, 1, 0, 0, 8'd0, 0);
        ticks(1); settle();
        check("resume_tick", int'(timeLeft), 29);

        ticks(19); idle(); settle();
        check("warn_at10", int'(timeLeft), 10);
        check("warn_flag", int'(warning), 1);
        repeat (8) idle();
        ticks(10); settle();
        check("expire_time", int'(timeLeft), 0);
        check("expire_up", int'(timeUp), 1);
        check("expire_running", int'(running), 0);
        idle(); settle();
        check("up_one_cycle", int'(timeUp), 0);
        ticks(3);
        step(0, 0, 1, 0, 0, 8'd0, 0);
        repeat (4) idle();

        step(1, 0, 0, 0, 0, 8'd0, 0); settle();
        check("restart_time", int'(timeLeft), 60);
        check("restart_up", int'(timeUp), 0);
        ticks(55); idle(); settle();
        check("warn_at5", int'(timeLeft), 5);
        step(0, 0, 0, 0, 1, 8'd20, 1); settle();
        check("bonus_tick", int'(timeLeft), 24);
        check("bonus_warning", int'(warning), 0);
        check("bonus_running", int'(running), 1);

        step(0, 0, 0, 0, 1, 8'd226, 0); settle();
        check("to250", int'(timeLeft), 250);
        step(0, 0, 0, 0, 1, 8'd20, 0); settle();
        check("sat255", int'(timeLeft), 255);
        ticks(5);
        step(0, 0, 0, 0, 1, 8'd20, 1); settle();
        check("sat_tick254", int'(timeLeft), 254);
        step(0, 1, 0, 0, 1, 8'd3, 1);
        step(0, 0, 1, 0, 0, 8'd0, 0);

        step(1, 1, 1, 1, 1, 8'd9, 1); settle();
        check("abort_running", int'(running), 0);
        check("abort_hold", int'(timeLeft), 254);
        ticks(4);
        step(0, 0, 0, 0, 1, 8'd9, 0);
        step(0, 0, 1, 0, 0, 8'd0, 0);

        step(1, 0, 0, 0, 0, 8'd0, 0);
        ticks(57); idle(); settle();
        check("warn_at3", int'(timeLeft), 3);
        step(0, 0, 0, 0, 0, 8'd0, 1); resetN = 1'b0; settle();
        check("midrst_time", int'(timeLeft), 60);
        check("midrst_display", int'(displayEn), 1);
        check("midrst_running", int'(running), 0);
        @(negedge clk); resetN = 1'b1; idle();

        step(1, 0, 0, 0, 0, 8'd0, 0);
        ticks(59); idle(); settle();
        check("at1", int'(timeLeft), 1);
        step(0, 0, 0, 0, 0, 8'd0, 1); resetN = 1'b0; settle();
        check("rst_drops_up", int'(timeUp), 0);
        @(negedge clk); resetN = 1'b1; idle();
        repeat (3) idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
Level countdown controller driven by the shared slow-clock tick.
- Consumes the one-cycle seconds pulse and the 50%-duty blink square wave.
- Sequences the level timer through start/pause/resume/bonus/expire.
- Gates the on-screen timer display: blinks it during the warning window and after expiry.
- Sits between the slow clock generator and the game FSM / score-timer drawing logic.

Parameters:
TIME_W, 8, width of the seconds counter
START_TIME, 60, value loaded on start (seconds)
WARN_TIME, 10, warning entered when timeLeft becomes <= WARN_TIME and > 0
MAX_TIME, 255, saturation ceiling for bonus additions; must be <= 2^TIME_W-1

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
secTick  in  1  one-cycle pulse, once per second, from slow clock generator
blinkDuty50  in  1  0.5 Hz square wave from slow clock generator
start  in  1  pulse: load START_TIME, begin counting
pause  in  1  pulse: freeze countdown
resume  in  1  pulse: continue countdown
abort  in  1  pulse: return to IDLE
addTime  in  1  pulse: add bonus seconds
addAmount  in  TIME_W  bonus value, sampled with addTime
timeLeft  out  TIME_W  remaining seconds
running  out  1  high in RUN or WARN
warning  out  1  high in WARN
displayEn  out  1  timer-sprite draw enable
timeUp  out  1  one-cycle pulse on expiry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetN: sampled only at posedge clk; resetN=0 overrides all other inputs.
- Reset values: state=IDLE, timeLeft=START_TIME, running=0, warning=0, displayEn=1, timeUp=0.
- All outputs are registered. Each output reflects an input event one cycle after the edge that samples it.
- States: IDLE, RUN, WARN, PAUSED, EXPIRED. PAUSED keeps a 1-bit return flag (RUN or WARN).
- Input priority within a cycle: abort > start > pause > resume > (addTime, secTick).
- abort: any state -> IDLE. timeLeft is held.
- start: any state (including RUN, WARN, PAUSED, EXPIRED) -> timeLeft=START_TIME, state=RUN. Any secTick or addTime in the same cycle is ignored.
- pause: RUN/WARN -> PAUSED and record the return state. Ignored in other states.
- resume: PAUSED -> recorded state. Ignored elsewhere.
- secTick and addTime are honoured only in RUN/WARN. In IDLE, PAUSED and EXPIRED they are ignored.
- Arithmetic: compute in TIME_W+1 bits.
  - sum = min(timeLeft + (addTime ? addAmount : 0), MAX_TIME).
  - next = sum - (secTick ? 1 : 0).
  - Tick and bonus in the same cycle are both applied: add first, saturate, then decrement.
- State after an update in RUN/WARN:
  - next == 0: go to EXPIRED, timeLeft=0, timeUp=1 for exactly one cycle.
  - 0 < next <= WARN_TIME: go to WARN.
  - otherwise: go to RUN. A bonus in WARN that lifts next above WARN_TIME therefore returns to RUN.
- START_TIME <= WARN_TIME is legal: start then enters RUN and the first tick moves to WARN.
- timeLeft never wraps below 0 or above MAX_TIME.
- displayEn:
  - 1 in IDLE, RUN and PAUSED.
  - equals registered blinkDuty50 in WARN and EXPIRED.
- running = (state == RUN || state == WARN). warning = (state == WARN).
- timeUp is asserted only on the RUN/WARN -> EXPIRED transition and never again until a new start.
- Reset mid-count: everything returns to reset values on the next edge. A pending timeUp is dropped.

Decomposition:
- Package game_timer_pkg:
  - enum timer_state_t {IDLE, RUN, WARN, PAUSED, EXPIRED}.
  - Default constants TIMER_W=8, TIMER_START=60, TIMER_WARN=10, TIMER_MAX=255.
- One natural sub-module: timer_to_digits, a combinational split of timeLeft into tens/units BCD for the digit drawer. It is instantiated by the top level, not inside this block.
- game_timer_ctrl itself is one FSM plus the saturating arithmetic.

Test Plan:
- Reset with START_TIME=60, then start, then 50 secTick pulses -> timeLeft=10, warning=1, displayEn tracks blinkDuty50; 10 more ticks -> timeLeft=0, timeUp high exactly 1 cycle, state EXPIRED, running=0.
- Pause at timeLeft=30, then 5 secTick pulses -> timeLeft stays 30; resume, then 1 tick -> 29.
- In WARN at timeLeft=5: addTime with addAmount=20 and secTick in the same cycle -> timeLeft=24, warning=0, running=1.
- timeLeft=250, addAmount=20 -> timeLeft=255 (saturated, MAX_TIME). In the same cycle as a tick -> 254.
- start, pause, resume and abort all asserted in one cycle while in RUN -> IDLE. start alone in EXPIRED -> timeLeft=60, RUN, no timeUp.
- resetN=0 for one edge while in WARN at timeLeft=3 with secTick high -> next cycle: IDLE, timeLeft=60, displayEn=1, timeUp=0.
